adc_scan_ctrl: RTL and testbench

//   Initiator side of the ADC conversion handshake. Generates adc_clk from a free-running divider and

---
 rtl/adc_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_ctrl.sv
// ADC conversion initiator: round-robin scan of the channels enabled in ch_mask,
// with start/ready handshake, per-sample strobe and a sticky timeout flag.
module adc_scan_ctrl #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 14,
  parameter int DIV_BIT = 5,
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         ch_mask,
  output logic                      adc_clk,
  output logic                      adc_start,
  input  logic                      adc_ready,
  input  logic [DATA_W-1:0]         adc_value,
  output logic [$clog2(NUM_CH)-1:0] adc_channel_ind,
  output logic [3:0]                adc_counts,
  output logic                      sample_valid,
  output logic [$clog2(NUM_CH)-1:0] sample_ch,
  output logic [DATA_W-1:0]         sample_data,
  output logic [DATA_W-1:0]         adc_current_0,
  output logic                      timeout_err
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = DIV_BIT + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SELECT, START, WAIT_RDY, CAPTURE, NEXT} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   clk_count;
  logic [TMR_W-1:0]   tmr;
  logic [CH_W-1:0]    ptr, ptr_nx;
  logic               load_ptr, capture, timed_out, skip_wait;
  logic               rdy_s1, rdy_s2, rdy_prev, rdy_rise;

  function automatic logic [CH_W-1:0] next_enabled(input logic [CH_W-1:0] cur,
                                                   input logic [NUM_CH-1:0] mask);
    logic [CH_W-1:0] pick;
    logic [CH_W-1:0] c;
    logic            found;
    pick  = cur;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      c = CH_W'((32'(cur) + i) % NUM_CH);
      if (!found && mask[c]) begin
        pick  = c;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_count <= '0;
      rdy_s1    <= 1'b0;
      rdy_s2    <= 1'b0;
      rdy_prev  <= 1'b0;
    end else begin
      clk_count <= clk_count + 1'b1;
      rdy_s1    <= adc_ready;
      rdy_s2    <= rdy_s1;
      rdy_prev  <= rdy_s2;
    end
  end

  assign adc_clk   = clk_count[DIV_BIT];
  assign rdy_rise  = rdy_s2 & ~rdy_prev;
  assign adc_start = (state == START) && enable;

  // START is entered on the edge where clk_count wraps, so it spans exactly one
  // full adc_clk period beginning at clk_count = 0 and ends when it reaches all-ones.
  always_comb begin
    state_nx  = state;
    load_ptr  = 1'b0;
    capture   = 1'b0;
    timed_out = 1'b0;
    ptr_nx    = next_enabled(ptr, ch_mask);
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (|ch_mask) begin
          state_nx = SELECT;
          load_ptr = 1'b1;
        end
        SELECT: if (tmr >= TMR_W'(SETTLE - 1) && clk_count == '1) state_nx = START;
        START:  if (clk_count == '1) state_nx = WAIT_RDY;
        WAIT_RDY: begin
          if (rdy_rise) begin
            state_nx = CAPTURE;
          end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
            state_nx  = NEXT;
            timed_out = 1'b1;
          end
        end
        CAPTURE: begin
          capture  = 1'b1;
          state_nx = NEXT;
        end
        NEXT: if (skip_wait || !rdy_s2) begin
          if (|ch_mask) begin
            state_nx = SELECT;
            load_ptr = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      tmr             <= '0;
      ptr             <= CH_W'(NUM_CH - 1);
      adc_channel_ind <= '0;
      skip_wait       <= 1'b0;
      sample_valid    <= 1'b0;
      sample_ch       <= '0;
      sample_data     <= '0;
      adc_current_0   <= '0;
      adc_counts      <= '0;
      timeout_err     <= 1'b0;
    end else begin
      state        <= state_nx;
      tmr          <= (state_nx != state) ? '0 : tmr + 1'b1;
      sample_valid <= capture;
      if (load_ptr) begin
        ptr             <= ptr_nx;
        adc_channel_ind <= ptr_nx;
      end
      // Remembers, through NEXT, whether the conversion was abandoned.
      if (state == WAIT_RDY) skip_wait <= timed_out;
      if (capture) begin
        sample_data <= adc_value;
        sample_ch   <= ptr;
        adc_counts  <= adc_counts + 1'b1;
        if (ptr == '0) adc_current_0 <= adc_value;
      end
      if (!enable)        timeout_err <= 1'b0;
      else if (timed_out) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Self-checking bench for adc_scan_ctrl: ADC responder model, transaction
// scoreboard, per-cycle compare process and directed scenario sequence.
module tb_adc_scan_ctrl;
  localparam int NUM_CH  = 8;
  localparam int DATA_W  = 14;
  localparam int DIV_BIT = 5;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 4095;
  localparam int PER     = 10;

  logic              clk = 1'b0;
  logic              rst_n, enable, adc_ready;
  logic [7:0]        ch_mask;
  logic [DATA_W-1:0] adc_value;
  logic              adc_clk, adc_start, sample_valid, timeout_err;
  logic [2:0]        adc_channel_ind, sample_ch;
  logic [3:0]        adc_counts;
  logic [DATA_W-1:0] sample_data, adc_current_0;

  adc_scan_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIV_BIT(DIV_BIT),
                  .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask),
    .adc_clk(adc_clk), .adc_start(adc_start), .adc_ready(adc_ready),
    .adc_value(adc_value), .adc_channel_ind(adc_channel_ind),
    .adc_counts(adc_counts), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .adc_current_0(adc_current_0),
    .timeout_err(timeout_err)
  );

  always #(PER/2) clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {int ch; int val; time t;} exp_t;
  exp_t exq[$];
  exp_t e;
  int   hist_ch[$];
  int   hist_val[$];
  int   adc_mode = 0;          // 0 fixed ch*100+7, 1 random, 2 never ready
  int   epoch = 0;
  int   nsamples = 0;
  int   nstarts = 0;

  // Free-running cycle count since reset release; its low bits are the divider.
  logic [31:0] cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 1;

  // ADC responder
  initial begin
    adc_ready = 1'b0;
    adc_value = '0;
    forever begin
      int ch, val, dly, ep;
      @(posedge adc_start);
      ch = int'(adc_channel_ind);
      ep = epoch;
      if (adc_mode == 2) continue;
      val = (adc_mode == 0) ? ch * 100 + 7 : int'($urandom_range(0, 16383));
      dly = (adc_mode == 0) ? 3 * 64 : int'($urandom_range(70, 300));
      repeat (dly) @(negedge clk);
      if (ep != epoch) continue;
      adc_value = DATA_W'(val);
      adc_ready = 1'b1;
      if (enable) exq.push_back('{ch, val, $time});
      repeat (8) @(negedge clk);
      adc_ready = 1'b0;
    end
  end

  function automatic int next_set(input int p, input logic [7:0] m);
    for (int k = 1; k <= NUM_CH; k++)
      if (m[(p + k) % NUM_CH]) return (p + k) % NUM_CH;
    return p;
  endfunction

  int   m_ptr = NUM_CH - 1;
  int   m_counts = 0;
  int   m_cur0 = 0;
  logic prev_start = 1'b0;
  logic prev_err = 1'b0;
  time  start_time = 0;
  time  fall_time = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exq.delete();
      m_ptr = NUM_CH - 1; m_counts = 0; m_cur0 = 0;
      prev_start = 1'b0; prev_err = 1'b0;
    end else begin
      check("adc_clk", 32'(adc_clk), 32'(cyc[DIV_BIT]));
      if (!enable) check("start_gated", 32'(adc_start), 0);
      if (adc_start && !prev_start) begin
        nstarts++;
        check("start_phase", 32'(cyc[DIV_BIT:0]), 0);
        check("start_ch", 32'(adc_channel_ind), 32'(next_set(m_ptr, ch_mask)));
        m_ptr = next_set(m_ptr, ch_mask);
        start_time = $time;
      end
      if (!adc_start && prev_start && enable) begin
        check("start_width", 32'(($time - start_time) / PER), 64);
        fall_time = $time;
      end
      if (timeout_err && !prev_err)
        check("timeout_cycles", 32'(($time - fall_time) / PER), TIMEOUT);
      if (sample_valid) begin
        if (exq.size() == 0) begin
          check("unexpected_sample", 32'(sample_valid), 0);
        end else begin
          e = exq.pop_front();
          m_counts = (m_counts + 1) % 16;
          if (e.ch == 0) m_cur0 = e.val;
          check("sample_ch", 32'(sample_ch), 32'(e.ch));
          check("sample_data", 32'(sample_data), 32'(e.val));
          check("sample_latency", 32'(($time - e.t) / PER), 4);
          check("adc_counts", 32'(adc_counts), 32'(m_counts));
          check("adc_current_0", 32'(adc_current_0), 32'(m_cur0));
          hist_ch.push_back(int'(sample_ch));
          hist_val.push_back(int'(sample_data));
          nsamples++;
        end
      end
      prev_start = adc_start;
      prev_err   = timeout_err;
    end
  end

  task automatic wait_samples(input int n);
    int tgt = nsamples + n;
    int budget = n * 1500;
    while (nsamples < tgt && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("wait_samples", 32'(nsamples >= tgt), 1);
  endtask

  task automatic wait_starts(input int n, input int budget);
    int tgt = nstarts + n;
    while (nstarts < tgt && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("wait_start", 32'(nstarts >= tgt), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_adc_clk"},       32'(adc_clk), 0);
    check({tag, "_adc_start"},     32'(adc_start), 0);
    check({tag, "_channel_ind"},   32'(adc_channel_ind), 0);
    check({tag, "_adc_counts"},    32'(adc_counts), 0);
    check({tag, "_sample_valid"},  32'(sample_valid), 0);
    check({tag, "_sample_ch"},     32'(sample_ch), 0);
    check({tag, "_sample_data"},   32'(sample_data), 0);
    check({tag, "_adc_current_0"}, 32'(adc_current_0), 0);
    check({tag, "_timeout_err"},   32'(timeout_err), 0);
  endtask

  initial begin
    int h0, n0, budget;
    rst_n = 1'b0; enable = 1'b0; ch_mask = '0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Two-channel scan with fixed ADC values
    h0 = hist_ch.size();
    adc_mode = 0; ch_mask = 8'h05; enable = 1'b1;
    wait_samples(5);
    enable = 1'b0;
    check("t1_s0_ch", 32'(hist_ch[h0]), 0);
    check("t1_s0_val", 32'(hist_val[h0]), 7);
    check("t1_s1_ch", 32'(hist_ch[h0 + 1]), 2);
    check("t1_s1_val", 32'(hist_val[h0 + 1]), 207);
    check("t1_s2_ch", 32'(hist_ch[h0 + 2]), 0);
    check("t1_counts", 32'(adc_counts), 5);
    check("t1_current_0", 32'(adc_current_0), 7);
    repeat (20) @(negedge clk);

    // Single enabled channel
    h0 = hist_ch.size();
    ch_mask = 8'h80; enable = 1'b1;
    wait_samples(3);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t6_ch", 32'(hist_ch[h0 + i]), 7);
      check("t6_val", 32'(hist_val[h0 + i]), 707);
    end
    check("t6_ind", 32'(adc_channel_ind), 7);
    check("t6_counts", 32'(adc_counts), 8);
    repeat (20) @(negedge clk);

    // ADC never answers: timeout, then the scan moves on
    n0 = nsamples;
    adc_mode = 2; ch_mask = 8'h12; enable = 1'b1;
    budget = 6000;
    while (!timeout_err && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("t3_timeout_seen", 32'(timeout_err), 1);
    wait_starts(1, 300);
    check("t3_next_ch", 32'(adc_channel_ind), 4);
    check("t3_no_samples", 32'(nsamples), 32'(n0));
    enable = 1'b0;
    @(negedge clk);
    check("t3_err_cleared", 32'(timeout_err), 0);
    repeat (20) @(negedge clk);

    // Enable dropped while waiting for ready
    adc_mode = 0; ch_mask = 8'h05; enable = 1'b1;
    wait_starts(1, 300);
    budget = 100;
    while (adc_start && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("t4_in_wait", 32'(adc_start), 0);
    repeat (20) @(negedge clk);
    n0 = nsamples;
    enable = 1'b0;
    @(negedge clk);
    check("t4_start_low", 32'(adc_start), 0);
    check("t4_err_low", 32'(timeout_err), 0);
    repeat (300) @(negedge clk);
    check("t4_no_sample", 32'(nsamples), 32'(n0));
    check("t4_ind_kept", 32'(adc_channel_ind), 0);

    // Randomized masks and ADC timing/values
    adc_mode = 1;
    for (int r = 0; r < 4; r++) begin
      ch_mask = 8'($urandom_range(1, 255));
      enable = 1'b1;
      wait_samples(5);
      enable = 1'b0;
      repeat (20) @(negedge clk);
    end
    check("counts_wrapped", 32'(adc_counts), 32'(nsamples % 16));

    // Reset in the middle of START
    adc_mode = 0; ch_mask = 8'h05; enable = 1'b1;
    wait_starts(1, 300);
    repeat (5) @(negedge clk);
    check("t5_in_start", 32'(adc_start), 1);
    epoch++;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_start", 32'(adc_start), 0);
    check("post_reset_valid", 32'(sample_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
